// File: rtl/pifo_arb_pkg.sv
// Shared types and defaults for the PIFO task arbiter.
// The task_t fields are sized for the widest supported build, which is
// payloads of up to 32 bits and tree ids of up to 8 bits. Narrower builds
// tie the upper bits of these fields to zero.
package pifo_arb_pkg;

    localparam int PORTS_DEF      = 4;
    localparam int PTW_DEF        = 8;
    localparam int TREE_W_DEF     = 2;
    localparam int FIFO_DEPTH_DEF = 4;

    localparam int PTW_MAX    = 32;
    localparam int TREE_W_MAX = 8;

    typedef struct packed {
        logic                  push;
        logic                  pop;
        logic [PTW_MAX-1:0]    data;
        logic [TREE_W_MAX-1:0] tree_id;
    } task_t;

    // Width of a port index. It never drops below one bit.
    function automatic int port_idx_w(input int ports);
        return (ports > 1) ? $clog2(ports) : 1;
    endfunction

endpackage

// File: rtl/pifo_task_fifo.sv
// Per-port task FIFO.
// A write is accepted only when the registered count is below DEPTH. A
// dequeue in the same cycle does not create room for that write. A rejected
// write raises a one-cycle drop pulse. The full flag is registered and
// tracks the count after each edge.
module pifo_task_fifo
    import pifo_arb_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEF
) (
    input  logic  clk_i,
    input  logic  srst_i,
    input  logic  wrEn_i,
    input  task_t wrTask_i,
    input  logic  rdEn_i,
    output task_t head_o,
    output logic  empty_o,
    output logic  full_o,
    output logic  drop_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    task_t         mem_q [DEPTH];
    logic [AW-1:0] wrPtr_q, wrPtr_d;
    logic [AW-1:0] rdPtr_q, rdPtr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full_q, full_d;
    logic          drop_q, drop_d;
    logic          wrOk, rdOk;

    // Decide accept/dequeue from registered state, then derive next pointers, count and flags
    always_comb begin
        wrOk    = wrEn_i && (count_q < CW'(DEPTH));
        rdOk    = rdEn_i && (count_q != '0);
        wrPtr_d = wrOk ? wrPtr_q + AW'(1) : wrPtr_q;
        rdPtr_d = rdOk ? rdPtr_q + AW'(1) : rdPtr_q;
        count_d = count_q + CW'(wrOk) - CW'(rdOk);
        full_d  = (count_d == CW'(DEPTH));
        drop_d  = wrEn_i && !wrOk;
    end

    // Storage array; contents are don't-care until pointed at, so it is not reset
    always_ff @(posedge clk_i) begin
        if (wrOk) begin
            mem_q[wrPtr_q] <= wrTask_i;
        end
    end

    // Pointer, occupancy and flag registers
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
            full_q  <= full_d;
            drop_q  <= drop_d;
        end
    end

    assign head_o  = mem_q[rdPtr_q];
    assign empty_o = (count_q == '0);
    assign full_o  = full_q;
    assign drop_o  = drop_q;

endmodule

// File: rtl/pifo_task_arb.sv
// PIFO task arbiter.
// Each port has its own task FIFO. A round-robin arbiter feeds a single
// registered output stage toward the PIFO core. A separate demux routes
// core pop responses back to their ports.
// Optional feature: define PIFO_TASK_ARB_POP_PRIO_EN to make the arbiter
// prefer FIFOs whose head carries a pop. It still falls back to plain
// round-robin when no such head exists.
module pifo_task_arb
    import pifo_arb_pkg::*;
#(
    parameter  int PORTS      = PORTS_DEF,
    parameter  int PTW        = PTW_DEF,
    parameter  int TREE_W     = TREE_W_DEF,
    parameter  int FIFO_DEPTH = FIFO_DEPTH_DEF,
    localparam int PW         = port_idx_w(PORTS)
) (
    input  logic                          i_clk,
    input  logic                          i_srst,
    input  logic [PORTS-1:0]              i_push,
    input  logic [PORTS-1:0]              i_pop,
    input  logic [PORTS-1:0][PTW-1:0]     i_push_data,
    input  logic [PORTS-1:0][TREE_W-1:0]  i_tree_id,
    output logic [PORTS-1:0]              o_task_fifo_full,
    output logic [PORTS-1:0]              o_task_drop,
    output logic                          o_core_valid,
    output logic                          o_core_push,
    output logic                          o_core_pop,
    output logic [PTW-1:0]                o_core_data,
    output logic [TREE_W-1:0]             o_core_tree_id,
    output logic [PW-1:0]                 o_core_port,
    input  logic                          i_core_ready,
    input  logic                          i_core_rsp_valid,
    input  logic [PW-1:0]                 i_core_rsp_port,
    input  logic [PTW-1:0]                i_core_rsp_data,
    output logic [PORTS-1:0]              o_pop_valid,
    output logic [PORTS-1:0][PTW-1:0]     o_pop_data
);

    task_t                  wrTask   [PORTS];
    task_t                  headTask [PORTS];
    logic [PORTS-1:0]       wrEn, deqEn, fifoEmpty, nonEmpty, searchMask;
    logic [PW-1:0]          rrPtr_q, rrPtr_d;
    logic [PW-1:0]          grantIdx;
    logic                   grantValid;
    logic                   loadEn;
    logic                   coreValid_q, coreValid_d;
    task_t                  coreTask_q, coreTask_d;
    logic [PW-1:0]          corePort_q, corePort_d;
    logic [PORTS-1:0]       popValid_q, popValid_d;
    logic [PORTS-1:0][PTW-1:0] popData_q, popData_d;
    logic                   unused_pad;

    // The output stage can take a new task when it is empty or its current task is being accepted
    assign loadEn = !coreValid_q || i_core_ready;

    for (genvar p = 0; p < PORTS; p++) begin : g_port
        assign wrEn[p]     = i_push[p] | i_pop[p];
        assign wrTask[p]   = '{push:    i_push[p],
                               pop:     i_pop[p],
                               data:    PTW_MAX'(i_push_data[p]),
                               tree_id: TREE_W_MAX'(i_tree_id[p])};
        assign deqEn[p]    = loadEn && grantValid && (grantIdx == PW'(p));
        assign nonEmpty[p] = !fifoEmpty[p];

        pifo_task_fifo #(
            .DEPTH    (FIFO_DEPTH)
        ) u_fifo (
            .clk_i    (i_clk),
            .srst_i   (i_srst),
            .wrEn_i   (wrEn[p]),
            .wrTask_i (wrTask[p]),
            .rdEn_i   (deqEn[p]),
            .head_o   (headTask[p]),
            .empty_o  (fifoEmpty[p]),
            .full_o   (o_task_fifo_full[p]),
            .drop_o   (o_task_drop[p])
        );
    end

`ifdef PIFO_TASK_ARB_POP_PRIO_EN
    logic [PORTS-1:0] popHead;

    // Restrict the search to pop-carrying heads whenever at least one exists
    always_comb begin
        popHead = '0;
        for (int p = 0; p < PORTS; p++) begin
            popHead[p] = nonEmpty[p] && headTask[p].pop;
        end
        searchMask = (popHead != '0) ? popHead : nonEmpty;
    end
`else
    assign searchMask = nonEmpty;
`endif

    // Round-robin search: first candidate at or after rrPtr_q, wrapping past the last port
    always_comb begin
        grantValid = 1'b0;
        grantIdx   = '0;
        for (int i = 0; i < PORTS; i++) begin
            int            idxInt;
            logic [PW-1:0] idx;
            idxInt = int'(rrPtr_q) + i;
            if (idxInt >= PORTS) begin
                idxInt = idxInt - PORTS;
            end
            idx = PW'(idxInt);
            if (!grantValid && searchMask[idx]) begin
                grantValid = 1'b1;
                grantIdx   = idx;
            end
        end
    end

    // Output stage and pointer next-state: reload on opportunity, otherwise hold steady
    always_comb begin
        coreValid_d = coreValid_q;
        coreTask_d  = coreTask_q;
        corePort_d  = corePort_q;
        rrPtr_d     = rrPtr_q;
        if (loadEn) begin
            coreValid_d = grantValid;
            if (grantValid) begin
                coreTask_d = headTask[grantIdx];
                corePort_d = grantIdx;
                rrPtr_d    = (grantIdx == PW'(PORTS - 1)) ? '0 : grantIdx + PW'(1);
            end
        end
    end

    // Response demux: pulse the addressed port and latch its data; out-of-range ports match nothing
    always_comb begin
        popValid_d = '0;
        popData_d  = popData_q;
        for (int p = 0; p < PORTS; p++) begin
            if (i_core_rsp_valid && (i_core_rsp_port == PW'(p))) begin
                popValid_d[p] = 1'b1;
                popData_d[p]  = i_core_rsp_data;
            end
        end
    end

    // Arbiter, output stage and response registers
    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            rrPtr_q     <= '0;
            coreValid_q <= 1'b0;
            coreTask_q  <= '0;
            corePort_q  <= '0;
            popValid_q  <= '0;
            popData_q   <= '0;
        end else begin
            rrPtr_q     <= rrPtr_d;
            coreValid_q <= coreValid_d;
            coreTask_q  <= coreTask_d;
            corePort_q  <= corePort_d;
            popValid_q  <= popValid_d;
            popData_q   <= popData_d;
        end
    end

    assign o_core_valid   = coreValid_q;
    assign o_core_push    = coreTask_q.push;
    assign o_core_pop     = coreTask_q.pop;
    assign o_core_data    = coreTask_q.data[PTW-1:0];
    assign o_core_tree_id = coreTask_q.tree_id[TREE_W-1:0];
    assign o_core_port    = corePort_q;
    assign o_pop_valid    = popValid_q;
    assign o_pop_data     = popData_q;

    // The zero-padded upper field bits are folded together here so they are consumed somewhere
    assign unused_pad = ^{coreTask_q.data, coreTask_q.tree_id};

endmodule
